// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared definitions for the boot-time instruction loader.
//   - state_e            : loader FSM state encoding
//   - STREAM_MSB_FIRST   : byte order of the incoming stream (length and words)
//   - IMEM_DEPTH_DEFAULT : default instruction-memory depth in 16-bit words
//   - assemble_word()    : joins two stream bytes into a 16-bit value
package instr_loader_pkg;

  localparam int unsigned IMEM_DEPTH_DEFAULT = 256;

  // Both the length field and the instruction words arrive MSB first.
  localparam bit STREAM_MSB_FIRST = 1'b1;

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CHK,
    ST_DONE,
    ST_ERROR
  } state_e;

  function automatic logic [15:0] assemble_word(input logic [7:0] first,
                                                input logic [7:0] second);
    return STREAM_MSB_FIRST ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/instr_loader.sv
// instr_loader: boot-time program loader sitting in front of the instruction
// memory and PC. Receives a byte stream (valid/ready), reads a 16-bit length N,
// then N 16-bit words, writing them to imem at addresses 0..N-1. cpu_run is held
// low until the whole image has been committed.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 restart pulse, honoured only in DONE or ERROR
//   byte_valid/byte_data  incoming stream byte
//   byte_ready            loader can take a byte this cycle (combinational)
//   imem_we/addr/wdata    one-cycle instruction-memory write port
//   word_count            words written in the current load
//   cpu_run               image valid, CPU may fetch
//   load_err              high while in ERROR
//
// Build option: define INSTR_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte (XOR of all length and data bytes) before releasing the CPU.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic [ADDR_W-1:0] word_count,
  output logic              cpu_run,
  output logic              load_err
);

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [15:0]       imem_wdata_q, imem_wdata_d;
  logic [ADDR_W-1:0] word_count_q, word_count_d;
  logic              cpu_run_q, cpu_run_d;
  logic              load_err_q, load_err_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  logic        accept;
  logic        restart;
  logic [15:0] len_w;

  always_comb begin
    byte_ready = (state_q != ST_DONE) && (state_q != ST_ERROR);
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    hi_d         = hi_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    word_count_d = word_count_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    chk_d        = chk_q;
`endif

    accept  = byte_valid && byte_ready;
    restart = start && ((state_q == ST_DONE) || (state_q == ST_ERROR));
    // The byte latch holds the first byte of both the length and each word.
    len_w   = assemble_word(hi_q, byte_data);

    case (state_q)
      ST_LEN_HI: if (accept) begin
        hi_d    = byte_data;
        state_d = ST_LEN_LO;
      end
      ST_LEN_LO: if (accept) begin
        len_d = len_w;
        if ((len_w == 16'h0000) || (32'(len_w) > IMEM_DEPTH)) state_d = ST_ERROR;
        else                                                  state_d = ST_DATA_HI;
      end
      ST_DATA_HI: if (accept) begin
        hi_d    = byte_data;
        state_d = ST_DATA_LO;
      end
      ST_DATA_LO: if (accept) begin
        imem_we_d    = 1'b1;
        imem_addr_d  = word_count_q;
        imem_wdata_d = len_w;
        word_count_d = word_count_q + ADDR_W'(1);
        if ((32'(word_count_q) + 32'd1) < 32'(len_q)) state_d = ST_DATA_HI;
`ifdef INSTR_LOADER_CHECKSUM_EN
        else                                          state_d = ST_CHK;
`else
        else                                          state_d = ST_DONE;
`endif
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      ST_CHK: if (accept) begin
        state_d = (byte_data == chk_q) ? ST_DONE : ST_ERROR;
      end
`endif
      ST_DONE, ST_ERROR: if (restart) begin
        state_d      = ST_LEN_HI;
        word_count_d = '0;
      end
      default: state_d = ST_ERROR;
    endcase

`ifdef INSTR_LOADER_CHECKSUM_EN
    if (accept && (state_q != ST_CHK)) chk_d = chk_q ^ byte_data;
    if (restart)                       chk_d = '0;
`endif

    // cpu_run follows DONE one cycle late so the final write lands first.
    cpu_run_d  = (state_q == ST_DONE) && !start;
    load_err_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LEN_HI;
      len_q        <= '0;
      hi_q         <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      word_count_q <= '0;
      cpu_run_q    <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      hi_q         <= hi_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      word_count_q <= word_count_d;
      cpu_run_q    <= cpu_run_d;
      load_err_q   <= load_err_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign word_count = word_count_q;
  assign cpu_run    = cpu_run_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: scoreboard bench for instr_loader. Expected writes
// {addr, data} are queued as words are streamed and popped when imem_we fires.
module tb_instr_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic [15:0] word_count;
  logic        cpu_run;
  logic        load_err;

  instr_loader #(.IMEM_DEPTH(256), .ADDR_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .word_count (word_count),
    .cpu_run    (cpu_run),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned writes = 0;
  logic [31:0] sb[$];
  logic [15:0] img[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every imem_we pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      writes++;
      if (sb.size() == 0) begin
        check("unexpected_we", 32'(imem_addr), 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        check("we_addr", 32'(imem_addr), 32'(e[31:16]));
        check("we_data", 32'(imem_wdata), 32'(e[15:0]));
      end
    end
  end

  // Called and returns at a negedge; byte is accepted at the posedge in between.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int unsigned guard;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    guard = 0;
    while (!byte_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_cpu_run", 32'(cpu_run), 32'd0);
    check("restart_load_err", 32'(load_err), 32'd0);
    check("restart_word_count", 32'(word_count), 32'd0);
    check("restart_ready", 32'(byte_ready), 32'd1);
  endtask

  // Streams img[] as a complete image from LEN_HI and checks the release timing.
  task automatic run_load(input bit gaps);
    logic [15:0] n;
    logic [7:0]  x;
    int unsigned w0;
    n  = 16'(img.size());
    w0 = writes;
    send_byte(n[15:8], gaps);
    send_byte(n[7:0], gaps);
    x = n[15:8] ^ n[7:0];
    for (int i = 0; i < img.size(); i++) begin
      sb.push_back({16'(i), img[i]});
      send_byte(img[i][15:8], gaps);
      send_byte(img[i][7:0], gaps);
      x = x ^ img[i][15:8] ^ img[i][7:0];
    end
    check("last_we_high", 32'(imem_we), 32'd1);
    check("cpu_run_during_last_we", 32'(cpu_run), 32'd0);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(x, gaps);
    check("cpu_run_after_chk_byte", 32'(cpu_run), 32'd0);
`endif
    @(negedge clk);
    check("cpu_run_released", 32'(cpu_run), 32'd1);
    check("we_one_cycle", 32'(imem_we), 32'd0);
    check("word_count", 32'(word_count), 32'(n));
    check("write_count", writes - w0, 32'(n));
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic expect_len_error(input logic [7:0] h, input logic [7:0] l);
    int unsigned w0;
    w0 = writes;
    send_byte(h, 1'b0);
    send_byte(l, 1'b0);
    check("err_load_err", 32'(load_err), 32'd1);
    check("err_cpu_run", 32'(cpu_run), 32'd0);
    check("err_ready", 32'(byte_ready), 32'd0);
    // A byte offered while in ERROR is neither consumed nor written.
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    check("err_no_writes", writes - w0, 32'd0);
    check("err_still_err", 32'(load_err), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", 32'(imem_wdata), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(byte_ready), 32'd1);

    // Basic three-word image.
    img = '{16'h1021, 16'h2034, 16'h3145};
    run_load(1'b0);

    // start is the only way out of DONE; stray bytes are refused.
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    check("done_ready_low", 32'(byte_ready), 32'd0);
    check("done_holds_run", 32'(cpu_run), 32'd1);
    check("done_holds_count", 32'(word_count), 32'd3);
    pulse_start();

    // Zero length and over-depth length both fail without writing.
    expect_len_error(8'h00, 8'h00);
    pulse_start();
    expect_len_error(8'h01, 8'h01);
    pulse_start();

    // Full-depth image: 256 words, last at address 0xFF.
    img.delete();
    for (int i = 0; i < 256; i++) img.push_back(16'($urandom));
    run_load(1'b0);
    check("full_last_addr", 32'(imem_addr), 32'h0000_00FF);
    pulse_start();

    // Single word with random valid gaps.
    img = '{16'hABCD};
    run_load(1'b1);
    check("gap_addr", 32'(imem_addr), 32'd0);
    check("gap_data", 32'(imem_wdata), 32'h0000_ABCD);
    pulse_start();

    // Reset after the high byte of the second word.
    sb.push_back({16'd0, 16'hAABB});
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    begin
      int unsigned w0;
      w0 = writes;
      rst_n = 1'b0;
      #1;
      check("midrst_we", 32'(imem_we), 32'd0);
      check("midrst_addr", 32'(imem_addr), 32'd0);
      check("midrst_wdata", 32'(imem_wdata), 32'd0);
      check("midrst_count", 32'(word_count), 32'd0);
      check("midrst_run", 32'(cpu_run), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_no_write", writes - w0, 32'd0);
      check("midrst_ready", 32'(byte_ready), 32'd1);
    end
    img = '{16'h1021, 16'h2034, 16'h3145};
    run_load(1'b0);
    pulse_start();

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Explicit checksum vectors: 00^01^12^34 = 27.
    sb.push_back({16'd0, 16'h1234});
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h27, 1'b0);
    @(negedge clk);
    check("chk_good_run", 32'(cpu_run), 32'd1);
    check("chk_good_err", 32'(load_err), 32'd0);
    pulse_start();
    sb.push_back({16'd0, 16'h1234});
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h28, 1'b0);
    check("chk_bad_err", 32'(load_err), 32'd1);
    @(negedge clk);
    check("chk_bad_run", 32'(cpu_run), 32'd0);
    pulse_start();
`endif

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
